// File: rtl/rgb_fade_driver.sv
// RGB LED driver: ramps each channel linearly toward its colour-code target
// and renders the level as PWM whose duty only changes at period boundaries.
module rgb_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int BRIGHT   = 200,
  parameter int STEP_DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          colour,
  input  logic                enable,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic [PWM_BITS-1:0] level_r,
  output logic [PWM_BITS-1:0] level_g,
  output logic [PWM_BITS-1:0] level_b,
  output logic                fading
);

  localparam int                  SW        = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] ON_LEVEL  = PWM_BITS'(BRIGHT);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic {IDLE, FADE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_colour_q;
  logic                r_en_q;
  logic [SW-1:0]       r_step_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_level [3];
  logic [PWM_BITS-1:0] r_cmp [3];
  logic [2:0]          r_led;
  logic [PWM_BITS-1:0] w_tgt [3];
  logic [PWM_BITS-1:0] w_level_next [3];
  logic                w_step;
  logic                w_any_diff;
  logic                w_any_diff_next;

  // Targets come only from the registered inputs; a step moves each channel
  // one LSB toward its target and can never overshoot it.
  always_comb begin
    w_step          = (r_state == FADE) && (r_step_cnt == STEP_LAST);
    w_any_diff      = 1'b0;
    w_any_diff_next = 1'b0;
    w_next_state    = r_state;
    for (int c = 0; c < 3; c++) begin
      w_tgt[c]        = (r_en_q && r_colour_q[c]) ? ON_LEVEL : '0;
      w_level_next[c] = r_level[c];
      if (w_step) begin
        if (r_level[c] < w_tgt[c])
          w_level_next[c] = r_level[c] + 1'b1;
        else if (r_level[c] > w_tgt[c])
          w_level_next[c] = r_level[c] - 1'b1;
      end
      w_any_diff      = w_any_diff | (r_level[c] != w_tgt[c]);
      w_any_diff_next = w_any_diff_next | (w_level_next[c] != w_tgt[c]);
    end
    case (r_state)
      IDLE: if (w_any_diff) w_next_state = FADE;
      FADE: if (w_step && !w_any_diff_next) w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_colour_q <= '0;
      r_en_q     <= 1'b0;
      r_step_cnt <= '0;
      for (int c = 0; c < 3; c++) r_level[c] <= '0;
    end else begin
      r_colour_q <= colour;
      r_en_q     <= enable;
      if (r_state != FADE || r_step_cnt == STEP_LAST)
        r_step_cnt <= '0;
      else
        r_step_cnt <= r_step_cnt + 1'b1;
      for (int c = 0; c < 3; c++) r_level[c] <= w_level_next[c];
    end
  end

  // Compare values are shadow-loaded on the last count so a pulse never
  // changes width partway through a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
      r_led     <= '0;
      for (int c = 0; c < 3; c++) r_cmp[c] <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      for (int c = 0; c < 3; c++) begin
        r_led[c] <= (r_pwm_cnt < r_cmp[c]);
        if (r_pwm_cnt == '1) r_cmp[c] <= r_level[c];
      end
    end
  end

  assign led_r   = r_led[0];
  assign led_g   = r_led[1];
  assign led_b   = r_led[2];
  assign level_r = r_level[0];
  assign level_g = r_level[1];
  assign level_b = r_level[2];
  assign fading  = (r_state == FADE);

endmodule

// File: tb/tb_rgb_fade_driver.sv
// Self-checking bench for rgb_fade_driver with a small-scale configuration
// (4-bit PWM, on-level 8, 4 clocks per fade step).
module tb_rgb_fade_driver;

  localparam int PB     = 4;
  localparam int BR     = 8;
  localparam int SD     = 4;
  localparam int PERIOD = 1 << PB;

  logic          clk;
  logic          rst;
  logic [2:0]    colour;
  logic          enable;
  logic          led_r, led_g, led_b;
  logic [PB-1:0] level_r, level_g, level_b;
  logic          fading;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  int mLevel [3];
  int mDuty [3];
  int mLed [3];
  int mPwm, mPhase, mColQ, mEnQ;
  bit mFading;

  rgb_fade_driver #(.PWM_BITS(PB), .BRIGHT(BR), .STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable),
    .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .level_r(level_r), .level_g(level_g), .level_b(level_b),
    .fading(fading)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: a channel's brightness walks one unit toward its goal every
  // SD clocks of fading time; the LED is lit for the first 'duty' counts of
  // each period, where duty is the brightness sampled at the period's end.
  initial begin : model
    int goal [3];
    int nextLevel [3];
    bit stepNow, stillMoving;
    mPwm = 0; mPhase = 0; mColQ = 0; mEnQ = 0; mFading = 0;
    for (int c = 0; c < 3; c++) begin
      mLevel[c] = 0; mDuty[c] = 0; mLed[c] = 0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        mPwm = 0; mPhase = 0; mColQ = 0; mEnQ = 0; mFading = 0;
        for (int c = 0; c < 3; c++) begin
          mLevel[c] = 0; mDuty[c] = 0; mLed[c] = 0;
        end
      end else begin
        stepNow     = mFading && (mPhase == SD - 1);
        stillMoving = 0;
        for (int c = 0; c < 3; c++) begin
          goal[c] = (mEnQ != 0 && ((mColQ >> c) & 1) != 0) ? BR : 0;
          nextLevel[c] = mLevel[c];
          if (stepNow && mLevel[c] != goal[c])
            nextLevel[c] = mLevel[c] + ((goal[c] > mLevel[c]) ? 1 : -1);
          if (mFading ? (!stepNow || nextLevel[c] != goal[c]) : (mLevel[c] != goal[c]))
            stillMoving = 1;
          mLed[c] = (mPwm < mDuty[c]) ? 1 : 0;
          if (mPwm == PERIOD - 1) mDuty[c] = mLevel[c];
        end
        mPhase = (mFading && !stepNow) ? mPhase + 1 : 0;
        mFading = stillMoving;
        for (int c = 0; c < 3; c++) mLevel[c] = nextLevel[c];
        mPwm  = (mPwm + 1) % PERIOD;
        mColQ = int'(colour);
        mEnQ  = int'(enable);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic [2:0] colourV, input logic enableV);
    rst    = rstV;
    colour = colourV;
    enable = enableV;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkLevels(input string tag, input int r, input int g, input int b, input int f);
    checkOutput({tag, ".level_r"}, int'(level_r), r);
    checkOutput({tag, ".level_g"}, int'(level_g), g);
    checkOutput({tag, ".level_b"}, int'(level_b), b);
    checkOutput({tag, ".fading"}, int'(fading), f);
  endtask

  task automatic countRedHigh(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      waitEdges(1);
      cnt += int'(led_r);
    end
  endtask

  // Every-cycle comparison against the reference model.
  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("model.level_r", int'(level_r), mLevel[0]);
        checkOutput("model.level_g", int'(level_g), mLevel[1]);
        checkOutput("model.level_b", int'(level_b), mLevel[2]);
        checkOutput("model.led_r", int'(led_r), mLed[0]);
        checkOutput("model.led_g", int'(led_g), mLed[1]);
        checkOutput("model.led_b", int'(led_b), mLed[2]);
        checkOutput("model.fading", int'(fading), int'(mFading));
      end
    end
  end

  initial begin
    int cnt;
    applyStimulus(1, 3'b000, 0);
    waitEdges(2);
    checkEn = 1;
    checkLevels("reset", 0, 0, 0, 0);
    checkOutput("reset.leds", int'({led_b, led_g, led_r}), 0);

    // All off for 20 cycles
    applyStimulus(0, 3'b000, 1);
    waitEdges(20);
    checkLevels("off", 0, 0, 0, 0);

    // Red ramps up from idle
    applyStimulus(0, 3'b001, 1);
    waitEdges(1);
    checkOutput("red.fading_k", int'(fading), 0);
    waitEdges(1);
    checkOutput("red.fading_k1", int'(fading), 1);
    waitEdges(3);
    checkOutput("red.before_step", int'(level_r), 0);
    waitEdges(1);
    checkOutput("red.first_step", int'(level_r), 1);
    waitEdges(27);
    checkLevels("red.almost", 7, 0, 0, 1);
    waitEdges(1);
    checkLevels("red.done", 8, 0, 0, 0);
    waitEdges(PERIOD);
    countRedHigh(PERIOD, cnt);
    checkOutput("red.duty", cnt, 8);

    // Crossfade red -> cyan
    applyStimulus(0, 3'b110, 1);
    waitEdges(6);
    checkLevels("cross.first", 7, 1, 1, 1);
    waitEdges(27);
    checkLevels("cross.almost", 1, 7, 7, 1);
    waitEdges(1);
    checkLevels("cross.done", 0, 8, 8, 0);

    applyStimulus(0, 3'b000, 1);
    waitEdges(34);
    checkLevels("clear", 0, 0, 0, 0);

    // Red to 3, then redirect to blue mid-fade
    applyStimulus(0, 3'b001, 1);
    waitEdges(14);
    checkOutput("redir.start", int'(level_r), 3);
    applyStimulus(0, 3'b100, 1);
    waitEdges(3);
    checkLevels("redir.hold", 3, 0, 0, 1);
    waitEdges(1);
    checkLevels("redir.step", 2, 0, 1, 1);
    waitEdges(27);
    checkLevels("redir.almost", 0, 0, 7, 1);
    waitEdges(1);
    checkLevels("redir.done", 0, 0, 8, 0);

    // Level change mid-period keeps current pulse width
    applyStimulus(0, 3'b001, 1);
    waitEdges(40);
    checkLevels("pwm.full", 8, 0, 0, 0);
    for (int i = 0; i < PERIOD && mPwm != 0; i++) waitEdges(1);
    applyStimulus(0, 3'b000, 1);
    countRedHigh(PERIOD, cnt);
    checkOutput("pwm.current_period", cnt, 8);
    countRedHigh(PERIOD, cnt);
    checkOutput("pwm.next_period", cnt, 5);
    waitEdges(10);

    // White, then enable off, then reset during re-enable
    applyStimulus(0, 3'b111, 1);
    waitEdges(40);
    checkLevels("white.full", 8, 8, 8, 0);
    applyStimulus(0, 3'b111, 0);
    waitEdges(33);
    checkLevels("disable.almost", 1, 1, 1, 1);
    waitEdges(1);
    checkLevels("disable.done", 0, 0, 0, 0);
    applyStimulus(0, 3'b111, 1);
    waitEdges(18);
    checkLevels("reen.mid", 4, 4, 4, 1);
    applyStimulus(1, 3'b111, 1);
    waitEdges(1);
    checkLevels("rst.mid", 0, 0, 0, 0);
    checkOutput("rst.leds", int'({led_b, led_g, led_r}), 0);
    applyStimulus(0, 3'b000, 1);
    waitEdges(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
